// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between instruction fetch and
//               MEM-stage data accesses; drives pipeline stall and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              stop_m,
    output logic              stall,
    output logic              halted,
    output logic              timeout_err
);

    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int c_TCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX  = c_STARVE_W'(STARVE_MAX);
    localparam logic [c_TCNT_W-1:0]   c_TCNT_LAST   = c_TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    state_t                r_state,       w_state_nxt;
    logic [c_STARVE_W-1:0] r_starve,      w_starve_nxt;
    logic [c_TCNT_W-1:0]   r_tcnt,        w_tcnt_nxt;
    logic                  r_mem_req,     w_mem_req_nxt;
    logic                  r_mem_we,      w_mem_we_nxt;
    logic [ADDR_W-1:0]     r_mem_addr,    w_mem_addr_nxt;
    logic [DATA_W-1:0]     r_mem_wdata,   w_mem_wdata_nxt;
    logic                  r_if_ready,    w_if_ready_nxt;
    logic                  r_d_ready,     w_d_ready_nxt;
    logic [DATA_W-1:0]     r_if_rdata,    w_if_rdata_nxt;
    logic [DATA_W-1:0]     r_d_rdata,     w_d_rdata_nxt;
    logic                  r_halted,      w_halted_nxt;
    logic                  r_timeout_err, w_timeout_err_nxt;
    logic                  w_ready_now;
    logic                  w_done;
    logic [DATA_W-1:0]     w_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_starve      <= '0;
            r_tcnt        <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_if_ready    <= 1'b0;
            r_d_ready     <= 1'b0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
            r_halted      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_starve      <= w_starve_nxt;
            r_tcnt        <= w_tcnt_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_if_ready    <= w_if_ready_nxt;
            r_d_ready     <= w_d_ready_nxt;
            r_if_rdata    <= w_if_rdata_nxt;
            r_d_rdata     <= w_d_rdata_nxt;
            r_halted      <= w_halted_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_starve_nxt      = r_starve;
        w_tcnt_nxt        = r_tcnt;
        w_mem_req_nxt     = r_mem_req;
        w_mem_we_nxt      = r_mem_we;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_if_ready_nxt    = 1'b0;
        w_d_ready_nxt     = 1'b0;
        w_if_rdata_nxt    = r_if_rdata;
        w_d_rdata_nxt     = r_d_rdata;
        w_halted_nxt      = r_halted;
        w_timeout_err_nxt = r_timeout_err;
        // The ready cycle still shows the old request, so arbitration skips it.
        w_ready_now       = r_if_ready | r_d_ready;
        w_done            = mem_ack || (r_tcnt == c_TCNT_LAST);
        w_rdata           = mem_ack ? mem_rdata : '0;

        case (r_state)
            ST_IDLE: begin
                w_tcnt_nxt = '0;
                if (!if_req) begin
                    w_starve_nxt = '0;
                end
                if (!w_ready_now) begin
                    if (d_req && !(if_req && r_starve == c_STARVE_MAX)) begin
                        w_state_nxt     = ST_BUSY_D;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = d_we;
                        w_mem_addr_nxt  = d_addr;
                        w_mem_wdata_nxt = d_wdata;
                        if (if_req && r_starve != c_STARVE_MAX) begin
                            w_starve_nxt = r_starve + c_STARVE_W'(1);
                        end
                    end else if (if_req) begin
                        w_state_nxt    = ST_BUSY_I;
                        w_mem_req_nxt  = 1'b1;
                        w_mem_we_nxt   = 1'b0;
                        w_mem_addr_nxt = if_addr;
                        w_starve_nxt   = '0;
                    end else if (stop_m) begin
                        w_state_nxt  = ST_HALT;
                        w_halted_nxt = 1'b1;
                    end
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (w_done) begin
                    w_state_nxt   = ST_IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_tcnt_nxt    = '0;
                    if (!mem_ack) begin
                        w_timeout_err_nxt = 1'b1;
                    end
                    if (r_state == ST_BUSY_I) begin
                        w_if_ready_nxt = 1'b1;
                        w_if_rdata_nxt = w_rdata;
                    end else begin
                        w_d_ready_nxt = 1'b1;
                        w_d_rdata_nxt = w_rdata;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + c_TCNT_W'(1);
                end
            end
            ST_HALT: begin
                w_mem_req_nxt = 1'b0;
                w_halted_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign if_ready    = r_if_ready;
    assign d_ready     = r_d_ready;
    assign if_rdata    = r_if_rdata;
    assign d_rdata     = r_d_rdata;
    assign halted      = r_halted;
    assign timeout_err = r_timeout_err;
    assign stall       = (d_req && !r_d_ready) || (if_req && !r_if_ready) || r_halted;

endmodule
`default_nettype wire
